// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster geometry for the sync generator and pixel renderers.
// Holds default timing, derived totals, sync window bounds and coordinate width.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIV_W   = 4;

    localparam int unsigned VGA_DIV       = 4;
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Inclusive range test on a raster coordinate.
    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (32'(c) >= lo) && (32'(c) <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides clkvga down to the pixel rate; p_tick_o is high on the last cycle
// of each DIV-cycle period (constantly high when DIV is 1).
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV = VGA_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic p_tick_o
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign p_tick_o = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v pixel counters, registered sync/blanking outputs and
// a one-cycle frame_start pulse after the raster wraps to (0,0).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV       = VGA_DIV,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic               clkvga,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               p_tick,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_DISPLAY + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic               video_q, video_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_q, frame_d;
    logic               h_wrap, v_wrap;

    pixel_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_i   (clkvga),
        .rst_i   (reset),
        .p_tick_o(p_tick)
    );

    // Outputs are decoded from next-state counters so they switch on the same edge as x/y.
    always_comb begin
        h_wrap = p_tick && (h_q == H_LAST);
        v_wrap = h_wrap && (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (p_tick) begin
            h_d = h_wrap ? '0 : h_q + COORD_W'(1);
        end
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + COORD_W'(1);
        end
        video_d = (32'(h_d) < H_DISPLAY) && (32'(v_d) < V_DISPLAY);
        hsync_d = in_window(h_d, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d = in_window(v_d, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        frame_d = v_wrap;
    end

    always_ff @(posedge clkvga or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            video_q <= 1'b1;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            video_q <= video_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            frame_q <= frame_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign video_on    = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_q;

endmodule
